conv3x3_filter: RTL and testbench
=================================

CONV3X3_FILTER -- requirements
Module: conv3x3_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter NUM_PIX, default 8294400 (3840x2160), meaning output pixels per frame.
REQ-003 SHALL have port axi_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port axi_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_pixel_data  input  9*DATA_W  3x3 window p0..p8, raster order, p0 (top-left) in LSBs, p4 centre.
REQ-006 SHALL have port i_pixel_data_valid  input  1  window valid; accepted when high with o_ready high.
REQ-007 SHALL have port o_ready  output  1  block can accept a window this cycle.
REQ-008 SHALL have port i_mode  input  2  0=Sobel, 1=Gaussian, 2=sharpen, 3=bypass.
REQ-009 SHALL have port i_thresh_en  input  1  enables binary threshold on result.
REQ-010 SHALL have port i_threshold  input  DATA_W  threshold value.
REQ-011 SHALL have port o_convolved_data  output  DATA_W  filtered pixel.
REQ-012 SHALL have port o_convolved_data_valid  output  1  output pixel valid.
REQ-013 SHALL have port i_data_ready  input  1  downstream accepts output this cycle.
REQ-014 SHALL have port o_frame_done  output  1  one-cycle pulse after last pixel of frame handed off.

Function
REQ-015 SHALL be a 3-stage pipeline (S1 products/partial sums, S2 sums/abs, S3 normalise/clamp/threshold); latency from accepted input to o_convolved_data_valid SHALL be exactly 3 cycles when unstalled.
REQ-016 SHALL advance all stages on en = i_data_ready OR NOT o_convolved_data_valid; o_ready SHALL equal en (combinational).
REQ-017 SHALL capture i_mode, i_thresh_en and i_threshold with each accepted window and carry them down the pipeline; changes affect only windows accepted afterwards.
REQ-018 While o_convolved_data_valid=1 and i_data_ready=0, o_convolved_data and all stage contents SHALL hold unchanged; no window lost, duplicated or reordered.
REQ-019 Empty stages SHALL carry valid=0 (bubbles); a bubble at S3 SHALL be overwritten without waiting for i_data_ready.
REQ-020 Mode 0: Gx=(p2+2p5+p8)-(p0+2p3+p6), Gy=(p6+2p7+p8)-(p0+2p1+p2), signed DATA_W+4 bits; result=|Gx|+|Gy| saturated to 2^DATA_W-1.
REQ-021 Mode 1: result=(p0+2p1+p2+2p3+4p4+2p5+p6+2p7+p8)>>4, truncation, no saturation needed.
REQ-022 Mode 2: result=5*p4-(p1+p3+p5+p7), signed, clamped to [0, 2^DATA_W-1].
REQ-023 Mode 3: result=p4 unchanged.
REQ-024 With captured thresh_en=1, output SHALL be 2^DATA_W-1 if result >= threshold else 0; applied after clamping.
REQ-025 Frame counter SHALL increment on each output handshake (valid AND i_data_ready); on the handshake with count NUM_PIX-1 it SHALL wrap to 0 and o_frame_done SHALL pulse high the following cycle for exactly one cycle.
REQ-026 Simultaneous input accept and output handshake SHALL be supported every cycle (full throughput, one pixel/cycle).

Reset
REQ-027 axi_reset_n low SHALL immediately clear all stage valids, frame counter, o_convolved_data (0), o_convolved_data_valid (0), o_frame_done (0).
REQ-028 Reset mid-stream SHALL discard in-flight windows; first window accepted after release SHALL emit 3 cycles later with counter starting at 0.
REQ-029 o_ready SHALL be 1 during and after reset while i_data_ready=1 or pipeline empty.

Verification (DATA_W=8)
REQ-030 Flat window all 100, modes 0/1/2/3, thresh off -> outputs 0/100/100/100, each exactly 3 cycles after acceptance.
REQ-031 Sobel vertical edge: left column 0, right column 255 -> Gx=1020, Gy=0, output 255 (saturated); same with thresh_en=1, threshold 200 -> 255; threshold on flat 100 window -> 0.
REQ-032 Sharpen: centre 0, neighbours 255 -> 0 (clamped from -1020); centre 255, neighbours 0 -> 255 (clamped from 1275).
REQ-033 Stream 6 windows back-to-back, i_data_ready low for 5 cycles after first output -> output held stable, o_ready low once 3 stages full, all 6 outputs delivered in order, no duplicates.
REQ-034 NUM_PIX=16, 20 windows streamed with random i_data_ready -> o_frame_done single pulse one cycle after 16th handshake, counter wraps, no pulse by 20th.
REQ-035 Assert axi_reset_n low 2 cycles with 2 windows in flight -> outputs 0 asynchronously, in-flight windows never appear, next window emitted 3 cycles after acceptance.

Source files
------------

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: streaming 3x3 window filter with a 3-stage pipeline.
//   S1: per-mode partial sums of the window
//   S2: final sums / absolute values as one signed value
//   S3: normalise (Gaussian >>4), clamp to pixel range, optional binary threshold
// Ports:
//   axi_clk, axi_reset_n        clock, async active-low reset
//   i_pixel_data[9*DATA_W]      window p0..p8 raster order, p0 in LSBs, p4 centre
//   i_pixel_data_valid/o_ready  input handshake
//   i_mode                      0 Sobel, 1 Gaussian, 2 sharpen, 3 bypass
//   i_thresh_en, i_threshold    binary threshold applied after clamping
//   o_convolved_data(_valid)    output pixel, i_data_ready is downstream ready
//   o_frame_done                one-cycle pulse after the last pixel of a frame
module conv3x3_filter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_PIX = 8294400
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic [9*DATA_W-1:0]   i_pixel_data,
  input  logic                  i_pixel_data_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_mode,
  input  logic                  i_thresh_en,
  input  logic [DATA_W-1:0]     i_threshold,
  output logic [DATA_W-1:0]     o_convolved_data,
  output logic                  o_convolved_data_valid,
  input  logic                  i_data_ready,
  output logic                  o_frame_done
);

  // Gaussian sum reaches 16*(2^DATA_W-1), so five extra bits keep it positive when signed.
  localparam int unsigned SW = DATA_W + 5;
  localparam int unsigned CW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NUM_PIX - 1);
  localparam logic signed [SW-1:0] MaxVal = {{5{1'b0}}, {DATA_W{1'b1}}};

  logic en, handshake;
  assign en        = i_data_ready | ~o_convolved_data_valid;
  assign o_ready   = en;
  assign handshake = o_convolved_data_valid & i_data_ready;

  // Stage 1: partial sums
  logic [SW-1:0] px [9];
  logic [SW-1:0] a_d, b_d, c_d, d_d;

  always_comb begin
    for (int i = 0; i < 9; i++) px[i] = SW'(i_pixel_data[i*DATA_W +: DATA_W]);
  end

  always_comb begin
    a_d = '0;
    b_d = '0;
    c_d = '0;
    d_d = '0;
    unique case (i_mode)
      2'd0: begin
        a_d = px[2] + (px[5] << 1) + px[8];
        b_d = px[0] + (px[3] << 1) + px[6];
        c_d = px[6] + (px[7] << 1) + px[8];
        d_d = px[0] + (px[1] << 1) + px[2];
      end
      2'd1: begin
        a_d = px[0] + (px[1] << 1) + px[2] + (px[3] << 1);
        b_d = (px[4] << 2) + (px[5] << 1) + px[6] + (px[7] << 1) + px[8];
      end
      2'd2: begin
        a_d = (px[4] << 2) + px[4];
        b_d = px[1] + px[3] + px[5] + px[7];
      end
      2'd3: a_d = px[4];
    endcase
  end

  logic              s1_valid_q, s1_ten_q;
  logic [1:0]        s1_mode_q;
  logic [DATA_W-1:0] s1_thr_q;
  logic [SW-1:0]     s1_a_q, s1_b_q, s1_c_q, s1_d_q;

  // Stage 2: combine partials into one signed value
  logic signed [SW-1:0] gx, gy, abs_x, abs_y, s2_val_d;

  always_comb begin
    gx       = $signed(s1_a_q) - $signed(s1_b_q);
    gy       = $signed(s1_c_q) - $signed(s1_d_q);
    abs_x    = gx[SW-1] ? -gx : gx;
    abs_y    = gy[SW-1] ? -gy : gy;
    s2_val_d = '0;
    unique case (s1_mode_q)
      2'd0: s2_val_d = abs_x + abs_y;
      2'd1: s2_val_d = $signed(s1_a_q) + $signed(s1_b_q);
      2'd2: s2_val_d = gx;
      2'd3: s2_val_d = $signed(s1_a_q);
    endcase
  end

  logic                 s2_valid_q, s2_ten_q;
  logic [1:0]           s2_mode_q;
  logic [DATA_W-1:0]    s2_thr_q;
  logic signed [SW-1:0] s2_val_q;

  // Stage 3: normalise, clamp, threshold
  logic signed [SW-1:0] norm;
  logic [DATA_W-1:0]    clamped, res_d;

  always_comb begin
    norm = (s2_mode_q == 2'd1) ? (s2_val_q >>> 4) : s2_val_q;
    if (norm[SW-1])         clamped = '0;
    else if (norm > MaxVal) clamped = '1;
    else                    clamped = norm[DATA_W-1:0];
    if (s2_ten_q) res_d = (clamped >= s2_thr_q) ? '1 : '0;
    else          res_d = clamped;
  end

  logic [CW-1:0] cnt_q;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      s1_valid_q             <= 1'b0;
      s1_ten_q               <= 1'b0;
      s1_mode_q              <= '0;
      s1_thr_q               <= '0;
      s1_a_q                 <= '0;
      s1_b_q                 <= '0;
      s1_c_q                 <= '0;
      s1_d_q                 <= '0;
      s2_valid_q             <= 1'b0;
      s2_ten_q               <= 1'b0;
      s2_mode_q              <= '0;
      s2_thr_q               <= '0;
      s2_val_q               <= '0;
      o_convolved_data       <= '0;
      o_convolved_data_valid <= 1'b0;
      o_frame_done           <= 1'b0;
      cnt_q                  <= '0;
    end else begin
      o_frame_done <= handshake && (cnt_q == LastCnt);
      if (handshake) cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
      // Whole pipeline moves together; a stalled S3 freezes every stage.
      if (en) begin
        s1_valid_q             <= i_pixel_data_valid;
        s1_ten_q               <= i_thresh_en;
        s1_mode_q              <= i_mode;
        s1_thr_q               <= i_threshold;
        s1_a_q                 <= a_d;
        s1_b_q                 <= b_d;
        s1_c_q                 <= c_d;
        s1_d_q                 <= d_d;
        s2_valid_q             <= s1_valid_q;
        s2_ten_q               <= s1_ten_q;
        s2_mode_q              <= s1_mode_q;
        s2_thr_q               <= s1_thr_q;
        s2_val_q               <= s2_val_d;
        o_convolved_data_valid <= s2_valid_q;
        o_convolved_data       <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
module tb_conv3x3_filter;
  localparam int DW = 8;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [71:0]   i_pixel_data;
  logic          i_pixel_data_valid;
  logic          o_ready;
  logic [1:0]    i_mode;
  logic          i_thresh_en;
  logic [7:0]    i_threshold;
  logic [7:0]    o_convolved_data;
  logic          o_convolved_data_valid;
  logic          i_data_ready;
  logic          o_frame_done;

  always #5 clk = ~clk;

  conv3x3_filter #(.DATA_W(DW), .NUM_PIX(NP)) dut (
    .axi_clk               (clk),
    .axi_reset_n           (rst_n),
    .i_pixel_data          (i_pixel_data),
    .i_pixel_data_valid    (i_pixel_data_valid),
    .o_ready               (o_ready),
    .i_mode                (i_mode),
    .i_thresh_en           (i_thresh_en),
    .i_threshold           (i_threshold),
    .o_convolved_data      (o_convolved_data),
    .o_convolved_data_valid(o_convolved_data_valid),
    .i_data_ready          (i_data_ready),
    .o_frame_done          (o_frame_done)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int   hs_cnt = 0;
  int   fd_seen = 0;
  logic exp_fd = 1'b0;
  logic smp_valid, smp_ready, smp_fd, smp_acc, smp_hs;
  logic [7:0] smp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Plain-integer reference computed from the filter definitions.
  function automatic logic [7:0] ref_model(input logic [71:0] w, input logic [1:0] mode,
                                           input logic ten, input logic [7:0] thr);
    int p[9];
    int r, gx, gy;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*8 +: 8]);
    case (mode)
      2'd0: begin
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        r  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (r > 255) r = 255;
      end
      2'd1: r = (p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8]) / 16;
      2'd2: begin
        r = 5*p[4] - (p[1] + p[3] + p[5] + p[7]);
        if (r < 0) r = 0;
        if (r > 255) r = 255;
      end
      default: r = p[4];
    endcase
    if (ten) r = (r >= int'(thr)) ? 255 : 0;
    return 8'(r);
  endfunction

  function automatic logic [71:0] flat(input logic [7:0] v);
    return {9{v}};
  endfunction

  // Called at posedge+1: drive, sample, score, advance one clock.
  task automatic tick(input logic v, input logic [71:0] w, input logic [1:0] m,
                      input logic te, input logic [7:0] th, input logic dr);
    i_pixel_data_valid = v;
    i_pixel_data       = w;
    i_mode             = m;
    i_thresh_en        = te;
    i_threshold        = th;
    i_data_ready       = dr;
    #1;
    smp_valid = o_convolved_data_valid;
    smp_data  = o_convolved_data;
    smp_ready = o_ready;
    smp_fd    = o_frame_done;
    check("frame_done", 32'(smp_fd), 32'(exp_fd));
    if (smp_fd) fd_seen++;
    smp_hs = smp_valid && dr;
    if (smp_hs) begin
      check("out_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("out_data", 32'(smp_data), 32'(exp_q.pop_front()));
    end
    exp_fd = smp_hs && (hs_cnt % NP == NP - 1);
    if (smp_hs) hs_cnt++;
    smp_acc = v && smp_ready;
    if (smp_acc) exp_q.push_back(ref_model(w, m, te, th));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, '0, 2'd0, 1'b0, 8'd0, 1'b1);
  endtask

  // Single window, checks 3-cycle latency and a fixed expected value.
  task automatic single(input string tag, input logic [71:0] w, input logic [1:0] m,
                        input logic te, input logic [7:0] th, input logic [7:0] exp);
    tick(1'b1, w, m, te, th, 1'b1);
    check({tag, "_acc"}, 32'(smp_acc), 1);
    idle();
    check({tag, "_lat1"}, 32'(smp_valid), 0);
    idle();
    check({tag, "_lat2"}, 32'(smp_valid), 0);
    idle();
    check({tag, "_lat3"}, 32'(smp_valid), 1);
    check({tag, "_val"}, 32'(smp_data), 32'(exp));
  endtask

  logic [71:0] wv;
  logic [71:0] wins[6];
  logic [1:0]  modes[6];
  logic [7:0]  held;
  int idx, outs;

  initial begin
    rst_n = 1'b0;
    i_pixel_data_valid = 1'b0;
    i_pixel_data = '0;
    i_mode = 2'd0;
    i_thresh_en = 1'b0;
    i_threshold = '0;
    i_data_ready = 1'b1;
    #1;
    check("rst_valid", 32'(o_convolved_data_valid), 0);
    check("rst_data", 32'(o_convolved_data), 0);
    check("rst_fd", 32'(o_frame_done), 0);
    check("rst_ready", 32'(o_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Flat window, all modes
    single("flat_sobel", flat(8'd100), 2'd0, 1'b0, 8'd0, 8'd0);
    single("flat_gauss", flat(8'd100), 2'd1, 1'b0, 8'd0, 8'd100);
    single("flat_sharp", flat(8'd100), 2'd2, 1'b0, 8'd0, 8'd100);
    single("flat_bypass", flat(8'd100), 2'd3, 1'b0, 8'd0, 8'd100);

    // Vertical edge: right column 255, rest 0
    for (int i = 0; i < 9; i++) wv[i*8 +: 8] = (i % 3 == 2) ? 8'd255 : 8'd0;
    single("sobel_edge", wv, 2'd0, 1'b0, 8'd0, 8'd255);
    single("sobel_edge_thr", wv, 2'd0, 1'b1, 8'd200, 8'd255);
    single("sobel_flat_thr", flat(8'd100), 2'd0, 1'b1, 8'd200, 8'd0);

    // Sharpen clamps
    wv = flat(8'd255);
    wv[32 +: 8] = 8'd0;
    single("sharp_low", wv, 2'd2, 1'b0, 8'd0, 8'd0);
    wv = flat(8'd0);
    wv[32 +: 8] = 8'd255;
    single("sharp_high", wv, 2'd2, 1'b0, 8'd0, 8'd255);
    idle();
    check("drain_q", 32'(exp_q.size()), 0);

    // Back-to-back stream with a 5-cycle downstream stall
    for (int i = 0; i < 6; i++) begin
      wins[i]  = {8'($urandom), $urandom, $urandom};
      modes[i] = 2'($urandom_range(0, 3));
    end
    idx = 0;
    outs = 0;
    held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx < 6) tick(1'b1, wins[idx], modes[idx], 1'b0, 8'd0, !(cyc >= 3 && cyc < 8));
      else         tick(1'b0, '0, 2'd0, 1'b0, 8'd0, 1'b1);
      if (smp_acc) idx++;
      if (smp_hs) outs++;
      if (cyc == 3) held = smp_data;
      if (cyc >= 3 && cyc < 8) begin
        check("stall_ready", 32'(smp_ready), 0);
        check("stall_valid", 32'(smp_valid), 1);
        check("stall_hold", 32'(smp_data), 32'(held));
      end
    end
    check("stall_outs", 32'(outs), 6);
    check("stall_q", 32'(exp_q.size()), 0);

    // Frame counting from a clean counter
    rst_n = 1'b0;
    exp_q.delete();
    hs_cnt = 0;
    exp_fd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fd_seen = 0;
    idx = 0;
    outs = 0;
    for (int cyc = 0; cyc < 400 && outs < 20; cyc++) begin
      wv = {8'($urandom), $urandom, $urandom};
      tick(idx < 20, wv, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           8'($urandom), $urandom_range(0, 9) < 7);
      if (smp_acc) idx++;
      if (smp_hs) outs++;
    end
    check("frame_outs", 32'(outs), 20);
    idle();
    idle();
    check("frame_pulses", 32'(fd_seen), 1);

    // Reset with windows in flight
    tick(1'b1, flat(8'd77), 2'd3, 1'b0, 8'd0, 1'b1);
    tick(1'b1, flat(8'd88), 2'd3, 1'b0, 8'd0, 1'b1);
    i_pixel_data_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_convolved_data_valid), 0);
    check("mid_rst_data", 32'(o_convolved_data), 0);
    check("mid_rst_ready", 32'(o_ready), 1);
    exp_q.delete();
    hs_cnt = 0;
    exp_fd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_rst_valid", 32'(o_convolved_data_valid), 0);
    rst_n = 1'b1;
    single("post_rst", flat(8'd42), 2'd3, 1'b0, 8'd0, 8'd42);
    for (int i = 0; i < 4; i++) idle();
    check("post_rst_q", 32'(exp_q.size()), 0);
    check("post_rst_cnt", 32'(hs_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
